// File: rtl/arm_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : arm_pipe_pkg
// Desc   : Shared ARM pipeline control-field layout and EXE command encodings
// Rev    : 1.0  initial release
// ============================================================================
package arm_pipe_pkg;

  // ctrl vector layout: {wb_en, mem_r_en, mem_w_en, exe_cmd[3:0], b, s, valid}
  localparam int c_CTRL_W        = 10;
  localparam int c_CTRL_VALID    = 0;
  localparam int c_CTRL_S        = 1;
  localparam int c_CTRL_B        = 2;
  localparam int c_CTRL_CMD_LSB  = 3;
  localparam int c_CTRL_CMD_MSB  = 6;
  localparam int c_CTRL_MEM_W_EN = 7;
  localparam int c_CTRL_MEM_R_EN = 8;
  localparam int c_CTRL_WB_EN    = 9;

  // opnd = {imm, shift_operand[11:0], signed_imm_24[23:0]}
  localparam int c_SHIFT_OPND_W = 12;
  localparam int c_SIMM24_W     = 24;
  localparam int c_OPND_W       = 1 + c_SHIFT_OPND_W + c_SIMM24_W;
  localparam int c_REGS_NUM     = 3;

  typedef enum logic [3:0] {
    EXE_MOV = 4'b0001,
    EXE_MVN = 4'b1001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000
  } exe_cmd_e;

  // An invalid slot must never carry side-effecting control bits.
  function automatic logic [c_CTRL_W-1:0] mask_invalid(input logic [c_CTRL_W-1:0] c);
    logic [c_CTRL_W-1:0] m;
    m = c;
    if (!c[c_CTRL_VALID]) begin
      m[c_CTRL_WB_EN]    = 1'b0;
      m[c_CTRL_MEM_R_EN] = 1'b0;
      m[c_CTRL_MEM_W_EN] = 1'b0;
      m[c_CTRL_B]        = 1'b0;
      m[c_CTRL_S]        = 1'b0;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_reg_en_clr.sv
`default_nettype none
// ============================================================================
// Module : pipe_reg_en_clr
// Desc   : Width-parameterised register with enable and synchronous clear
// Rev    : 1.0  initial release
// ============================================================================
module pipe_reg_en_clr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // clear outranks enable so a kill is never lost behind a stall
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module : id_ex_stage_reg
// Desc   : ARM ID/EX pipeline register with freeze, flush and valid masking.
//          Define ID_EX_PERF_CNT_EN to add bubble/stall saturating counters.
// Rev    : 1.0  initial release
// ============================================================================
module id_ex_stage_reg
  import arm_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
`ifdef ID_EX_PERF_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        freeze,
  input  logic                        flush,
  input  logic [c_CTRL_W-1:0]         ctrl_in,
  input  logic [DATA_W-1:0]           pc_in,
  input  logic [DATA_W-1:0]           val_rn_in,
  input  logic [DATA_W-1:0]           val_rm_in,
  input  logic [c_OPND_W-1:0]         opnd_in,
  input  logic [c_REGS_NUM*REG_W-1:0] regs_in,
  input  logic                        carry_in,
  output logic [c_CTRL_W-1:0]         ctrl_out,
  output logic [DATA_W-1:0]           pc_out,
  output logic [DATA_W-1:0]           val_rn_out,
  output logic [DATA_W-1:0]           val_rm_out,
  output logic [c_OPND_W-1:0]         opnd_out,
  output logic [c_REGS_NUM*REG_W-1:0] regs_out,
  output logic                        carry_out
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]            bubble_cnt,
  output logic [CNT_W-1:0]            stall_cnt
`endif
);

  logic                  w_en;
  logic [c_CTRL_W-1:0]   w_ctrl_d;

  assign w_en     = ~freeze;
  assign w_ctrl_d = mask_invalid(ctrl_in);

  pipe_reg_en_clr #(.WIDTH(c_CTRL_W)) u_ctrl (
    .clk(clk), .rst(rst), .en(w_en), .clr(flush), .d(w_ctrl_d), .q(ctrl_out)
  );

  pipe_reg_en_clr #(.WIDTH(DATA_W)) u_pc (
    .clk(clk), .rst(rst), .en(w_en), .clr(flush), .d(pc_in), .q(pc_out)
  );

  pipe_reg_en_clr #(.WIDTH(2*DATA_W)) u_vals (
    .clk(clk), .rst(rst), .en(w_en), .clr(flush),
    .d({val_rn_in, val_rm_in}), .q({val_rn_out, val_rm_out})
  );

  pipe_reg_en_clr #(.WIDTH(c_OPND_W)) u_opnd (
    .clk(clk), .rst(rst), .en(w_en), .clr(flush), .d(opnd_in), .q(opnd_out)
  );

  pipe_reg_en_clr #(.WIDTH(c_REGS_NUM*REG_W + 1)) u_tags (
    .clk(clk), .rst(rst), .en(w_en), .clr(flush),
    .d({regs_in, carry_in}), .q({regs_out, carry_out})
  );

`ifdef ID_EX_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             w_bubble;
  logic             w_stall;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // a bubble is either a kill or an invalid slot actually being loaded
  assign w_bubble = flush | (~freeze & ~ctrl_in[c_CTRL_VALID]);
  assign w_stall  = freeze & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_bubble && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign stall_cnt  = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module : tb_id_ex_stage_reg
// Desc   : Directed scoreboard bench for id_ex_stage_reg (optional ID_EX_PERF_CNT_EN)
// Rev    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic [9:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [36:0] opnd;
    logic [11:0] regs;
    logic        carry;
    logic        chk_cnt;
    logic [1:0]  bcnt;
    logic [1:0]  scnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic [9:0]  ctrl_in = '0;
  logic [31:0] pc_in = '0;
  logic [31:0] val_rn_in = '0;
  logic [31:0] val_rm_in = '0;
  logic [36:0] opnd_in = '0;
  logic [11:0] regs_in = '0;
  logic        carry_in = 1'b0;
  logic [9:0]  ctrl_out;
  logic [31:0] pc_out;
  logic [31:0] val_rn_out;
  logic [31:0] val_rm_out;
  logic [36:0] opnd_out;
  logic [11:0] regs_out;
  logic        carry_out;
`ifdef ID_EX_PERF_CNT_EN
  logic [1:0]  bubble_cnt;
  logic [1:0]  stall_cnt;
`endif

  int   tests = 0;
  int   fails = 0;
  vec_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_stage_reg #(
    .DATA_W(32),
    .REG_W (4)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .CNT_W (2)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .flush     (flush),
    .ctrl_in   (ctrl_in),
    .pc_in     (pc_in),
    .val_rn_in (val_rn_in),
    .val_rm_in (val_rm_in),
    .opnd_in   (opnd_in),
    .regs_in   (regs_in),
    .carry_in  (carry_in),
    .ctrl_out  (ctrl_out),
    .pc_out    (pc_out),
    .val_rn_out(val_rn_out),
    .val_rm_out(val_rm_out),
    .opnd_out  (opnd_out),
    .regs_out  (regs_out),
    .carry_out (carry_out)
`ifdef ID_EX_PERF_CNT_EN
    ,
    .bubble_cnt(bubble_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  function automatic vec_t mk(input logic [9:0] c, input logic [31:0] pc, input logic [31:0] rn,
                              input logic [31:0] rm, input logic [36:0] op, input logic [11:0] rg,
                              input logic cy);
    vec_t v;
    v = '0;
    v.ctrl = c; v.pc = pc; v.rn = rn; v.rm = rm; v.opnd = op; v.regs = rg; v.carry = cy;
    return v;
  endfunction

  function automatic vec_t with_cnt(input vec_t v, input logic [1:0] b, input logic [1:0] s);
    vec_t r;
    r = v;
    r.chk_cnt = 1'b1; r.bcnt = b; r.scnt = s;
    return r;
  endfunction

  // Drive one cycle of stimulus and queue the output expected after the next edge.
  task automatic vec(input logic r, input logic fz, input logic fl, input vec_t in, input vec_t ex);
    @(negedge clk);
    rst = r; freeze = fz; flush = fl;
    ctrl_in = in.ctrl; pc_in = in.pc; val_rn_in = in.rn; val_rm_in = in.rm;
    opnd_in = in.opnd; regs_in = in.regs; carry_in = in.carry;
    exp_q.push_back(ex);
  endtask

  // Monitor: the register presents a slot every edge; compare against the scoreboard.
  initial begin
    vec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({ctrl_out, pc_out, val_rn_out, val_rm_out, opnd_out, regs_out, carry_out} !==
            {e.ctrl, e.pc, e.rn, e.rm, e.opnd, e.regs, e.carry}) begin
          fails++;
          $display("FAIL slot#%0d: got ctrl=%h pc=%h rn=%h rm=%h opnd=%h regs=%h c=%b, need ctrl=%h pc=%h rn=%h rm=%h opnd=%h regs=%h c=%b",
                   tests, ctrl_out, pc_out, val_rn_out, val_rm_out, opnd_out, regs_out, carry_out,
                   e.ctrl, e.pc, e.rn, e.rm, e.opnd, e.regs, e.carry);
        end
`ifdef ID_EX_PERF_CNT_EN
        if (e.chk_cnt) begin
          tests++;
          if (bubble_cnt !== e.bcnt || stall_cnt !== e.scnt) begin
            fails++;
            $display("FAIL perf_cnt#%0d: got bubble=%0d stall=%0d, need bubble=%0d stall=%0d",
                     tests, bubble_cnt, stall_cnt, e.bcnt, e.scnt);
          end
        end
`endif
      end
    end
  end

  initial begin
    vec_t zero, junk, add_v, mov_v, str_v, ldr_v, msk_i, msk_e;
    int   guard;
    zero  = '0;
    junk  = mk(10'h3FF, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 37'h1F_FFFF_FFFF, 12'hFFF, 1'b1);
    // ADD: {1,0,0,0010,0,1,1}
    add_v = mk(10'h213, 32'h0000_0010, 32'd5, 32'd7, 37'h01_2345_6789, 12'h123, 1'b1);
    // MOV: {1,0,0,0001,0,0,1}
    mov_v = mk(10'h209, 32'h0000_0014, 32'd9, 32'd11, 37'h00_0000_00FF, 12'h456, 1'b0);
    // STR: {0,0,1,0010,0,0,1}
    str_v = mk(10'h091, 32'h0000_0018, 32'h100, 32'h200, 37'h10_0000_0004, 12'h789, 1'b1);
    // LDR: {1,1,0,0010,0,0,1}
    ldr_v = mk(10'h311, 32'h0000_001C, 32'h300, 32'h0, 37'h00_0000_0008, 12'hA10, 1'b0);
    // invalid slot {1,0,1,0110,1,1,0}: only exe_cmd survives -> 0x030
    msk_i = mk(10'h2B6, 32'h0000_0020, 32'd1, 32'd2, 37'h3, 12'h321, 1'b1);
    msk_e = mk(10'h030, 32'h0000_0020, 32'd1, 32'd2, 37'h3, 12'h321, 1'b1);

    vec(1, 1, 1, junk,  zero);   // reset beats freeze and flush
    vec(0, 0, 0, add_v, add_v);  // plain load
    vec(0, 1, 0, mov_v, add_v);  // freeze x3 holds ADD
    vec(0, 1, 0, mov_v, add_v);
    vec(0, 1, 0, mov_v, add_v);
    vec(0, 0, 0, mov_v, mov_v);  // release takes new input
    vec(0, 0, 0, str_v, str_v);
    vec(0, 1, 1, str_v, zero);   // flush during freeze still kills
    vec(0, 0, 0, ldr_v, ldr_v);
    vec(0, 0, 0, msk_i, msk_e);  // valid=0 masks side-effect bits
    vec(0, 0, 1, add_v, zero);   // back-to-back bubbles
    vec(0, 0, 1, ldr_v, zero);
    vec(0, 1, 0, add_v, zero);   // freeze holds the bubble
    vec(0, 0, 0, add_v, add_v);

`ifdef ID_EX_PERF_CNT_EN
    vec(1, 0, 0, add_v, with_cnt(zero, 2'd0, 2'd0));
    vec(0, 0, 1, add_v, with_cnt(zero, 2'd1, 2'd0));
    vec(0, 0, 1, add_v, with_cnt(zero, 2'd2, 2'd0));
    vec(0, 0, 1, add_v, with_cnt(zero, 2'd3, 2'd0));
    vec(0, 0, 1, add_v, with_cnt(zero, 2'd3, 2'd0));  // saturates
    vec(0, 0, 1, add_v, with_cnt(zero, 2'd3, 2'd0));
    vec(0, 1, 0, add_v, with_cnt(zero, 2'd3, 2'd1));
    vec(0, 1, 0, add_v, with_cnt(zero, 2'd3, 2'd2));
    vec(1, 1, 1, junk,  with_cnt(zero, 2'd0, 2'd0));
`endif

    @(negedge clk);
    rst = 1'b0; freeze = 1'b1; flush = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected slots never compared, need 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the ARM pipeline.
- Sits directly downstream of the ID control-decode logic. Captures decoded control bits, operand values, immediate fields and register tags each cycle, and presents them to the EXE stage.
- Supports three operations: stall-hold (freeze), bubble insertion (flush on taken branch), and a valid tag per slot.

Parameters:
- DATA_W, 32, width of PC and register operand values
- REG_W, 4, register-index width
- CNT_W, 16, width of performance counters (only under the optional feature)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  hazard stall; hold all contents
- flush  in  1  taken branch in EXE; kill the instruction entering
- ctrl_in  in  10  {wb_en, mem_r_en, mem_w_en, exe_cmd[3:0], b, s, valid}, MSB first
- pc_in  in  DATA_W  PC+4 of the ID instruction
- val_rn_in  in  DATA_W  Rn register-file value
- val_rm_in  in  DATA_W  Rm register-file value
- opnd_in  in  37  {imm, shift_operand[11:0], signed_imm_24[23:0]}
- regs_in  in  3*REG_W  {dest, src1, src2}
- carry_in  in  1  status-register C flag sampled in ID
- ctrl_out  out  10  registered ctrl_in, same layout
- pc_out  out  DATA_W  registered pc_in
- val_rn_out  out  DATA_W  registered val_rn_in
- val_rm_out  out  DATA_W  registered val_rm_in
- opnd_out  out  37  registered opnd_in
- regs_out  out  3*REG_W  registered regs_in
- carry_out  out  1  registered carry_in

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-high.
- Reset (rst=1): every output register = 0, i.e. a NOP bubble with valid=0. Any freeze or flush in that cycle is ignored.
- Priority per edge: rst > flush > freeze > load.
- Flush:
  - Control fields wb_en, mem_r_en, mem_w_en, exe_cmd, b, s and valid are cleared.
  - Data fields (pc, val_rn, val_rm, opnd, regs, carry) are cleared as well.
  - A flush during freeze still clears; the kill must not be lost.
- Freeze (flush=0): all outputs hold their previous values.
- Load: all outputs take their inputs.
- Latency: exactly 1 cycle from input to output. There is no combinational path from input to output.
- Invariant: if valid_out=0, then wb_en, mem_r_en, mem_w_en, b and s are 0 in ctrl_out. This also applies when ctrl_in carries valid=0 with nonzero bits: those bits are masked on load.
- Back-to-back flushes produce consecutive bubbles.
- Freeze lasting N cycles holds one instruction for N+1 cycles of visibility.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN
- When defined, two CNT_W output ports are added:
  - bubble_cnt: increments on each edge where a flush occurs or an invalid instruction is loaded.
  - stall_cnt: increments on each freeze edge without flush.
- Both counters saturate at all-ones (no wrap) and clear on rst.
- When undefined, the ports and counters are absent and there is no other change.

Decomposition:
- Shared package arm_pipe_pkg holds:
  - ctrl field bit-position constants
  - EXE_CMD encodings (MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000)
  - the opnd/regs field widths
- One natural sub-module, pipe_reg_en_clr: a generic width-parameterised register with enable and synchronous clear. It is instantiated per field group.

Test Plan:
- Reset: assert rst with freeze=1, flush=1 and random inputs -> next edge all outputs 0.
- Load: ctrl_in={1,0,0,0010,0,1,1}, pc_in=0x0000_0010, val_rn_in=5 -> one edge later these appear unchanged on the outputs.
- Freeze: load ADD; hold freeze=1 for 3 cycles while changing inputs -> outputs stay ADD for 3 cycles, then take the new input on release.
- Flush vs freeze: freeze=1, flush=1 with STR held -> next edge ctrl_out=0 and valid=0. Then with flush=0, freeze=0, loading LDR -> LDR appears.
- Valid mask: ctrl_in valid=0, wb_en=1, mem_w_en=1 -> ctrl_out wb_en=0, mem_w_en=0.
- Perf counters (ID_EX_PERF_CNT_EN defined, CNT_W=2): 5 flushes -> bubble_cnt saturates at 3. 2 freezes -> stall_cnt=2. Then rst -> both 0.
